mdu_div: RTL and testbench
==========================

# mdu_div

Iterative 32-bit divider for the DIV/DIVU instructions, located in the multiply/divide unit beside the ALU. It computes the leading-zero count of the dividend magnitude with the CLZ unit, then skips those leading zeros, so a division runs one restoring step per significant dividend bit. It produces MIPS LO (quotient) and HI (remainder) values and raises a one-cycle `done` for the control unit to latch.

## Interface
- `WIDTH`, default 32: operand width. Only 32 is supported.
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `is_signed`  in  1  1 = DIV, 0 = DIVU; captured with `start`
- `dividend`  in  32  rs operand; captured with `start`
- `divisor`  in  32  rt operand; captured with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse; results valid
- `quotient`  out  32  LO result, registered
- `remainder`  out  32  HI result, registered
- `div_by_zero`  out  1  registered flag for the last operation

## Operation
- States: IDLE, LOAD, ITER, FIX, DONE.
- IDLE: when `start`=1, capture the operands and go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - Form magnitudes `|a|` and `|b|`. Negate only if `is_signed` is set and bit31 is set.
  - Count `n = 32 - clz(|a|)`, a 6-bit value in the range 0..32.
  - Load the quotient shift register with `|a| << clz(|a|)`. Clear the 33-bit partial remainder.
  - Record `qneg = is_signed & (a[31]^b[31])` and `rneg = is_signed & a[31]`.
  - If the divisor is 0, go to DONE. Else if n=0, go to FIX. Else go to ITER.
- ITER, one restoring step per cycle:
  - Shift {r,q} left by 1.
  - Compute `t = r - {1'b0,|b|}`. If `t >= 0`, set `r = t` and `q[0] = 1`.
  - Decrement n. Leave for FIX after the step in which n reaches 0.
- FIX:
  - `quotient = qneg ? -q : q`.
  - `remainder = rneg ? -r[31:0] : r[31:0]`.
  - Go to DONE.
- DONE:
  - `done` = 1 for exactly this cycle. Return to IDLE.
  - For a zero divisor: `quotient = 32'hFFFF_FFFF`, `remainder = dividend` as captured, `div_by_zero = 1`.
- Overflow case: 0x8000_0000 / 0xFFFF_FFFF signed falls out of the magnitude arithmetic as quotient 0x8000_0000, remainder 0. It needs no special case.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next LOAD. `div_by_zero` clears in LOAD.
- `start` is ignored while `busy` is high. There is no queueing and no abort input.

## Timing
- Cycle numbering: `start` is sampled at the end of cycle 0. LOAD is cycle 1. ITER is cycles 2..n+1. FIX is cycle n+2. DONE is cycle n+3.
- `done` rises in cycle n+3, for a latency of 3..35 cycles.
- Divide-by-zero: `done` in cycle 2.
- `busy` is high from cycle 1 through the DONE cycle inclusive. `start` in the cycle after DONE is accepted.
- Reset values: all outputs 0, state IDLE. Reset applies immediately when `rst_n` falls.
- Reset mid-operation: discard the operation and force all outputs to 0. No `done` is produced after release.

## Structure
- Shared package `mdu_pkg` holds:
  - the state encoding, as 3-bit localparams;
  - `MDU_W = 32`;
  - the divide-by-zero quotient constant 32'hFFFF_FFFF.
- The multiplier reuses the same package.
- One sub-module instance: the existing `CLZ` unit on `|a|`. Use its `dataout[5:0]` only.
- Everything else is flat: FSM, the 6-bit counter, 33-bit subtractor, shift registers and sign-fix negators.

## Test plan
- DIVU 100 / 7: `done` in cycle 10 (n=7), q=14, r=2, `div_by_zero`=0.
- DIV 0xFFFF_FFF9 / 2 (-7/2): q=0xFFFF_FFFD, r=0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF: q=0x8000_0000, r=0. Then DIVU 0xFFFF_FFFF / 1: `done` in cycle 35, q=0xFFFF_FFFF, r=0.
- DIVU 5 / 0: `done` in cycle 2, q=0xFFFF_FFFF, r=5, `div_by_zero`=1. A following DIVU 0 / 3 gives `done` in cycle 3, q=0, r=0, flag cleared.
- During ITER, pulse `start` with new operands: ignored, and the original result is unchanged.
- Drop `rst_n` during ITER: outputs go to 0 immediately and no `done` follows. A new `start` after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: state encoding, operand width
// and the quotient constant returned for a zero divisor.
package mdu_pkg;

   localparam int MDU_W = 32;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_ITER = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE = ST_IDLE,
      S_LOAD = ST_LOAD,
      S_ITER = ST_ITER,
      S_FIX  = ST_FIX,
      S_DONE = ST_DONE
   } div_state_e;

   localparam logic [MDU_W-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_div_clz.sv
// Count-leading-zeros unit: dataout = number of zero bits above the most
// significant set bit of datain, or 32 when datain is zero.
module CLZ (
   input  logic [31:0] datain,
   output logic [5:0]  dataout
);

   // Scan upward so the highest set bit is the last one to update the count.
   always_comb begin
      dataout = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (datain[i]) begin
            dataout = 6'(31 - i);
         end
      end
   end

endmodule

// File: rtl/mdu_div.sv
// Iterative restoring divider for DIV/DIVU. Leading zeros of the dividend
// magnitude are skipped up front, so only significant bits cost a cycle.
// Produces LO (quotient) and HI (remainder) plus a one-cycle done pulse.
module mdu_div
   import mdu_pkg::*;
#(
   parameter int WIDTH = MDU_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [WIDTH-1:0] q_sr_q, q_sr_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [5:0]       cnt_q, cnt_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [5:0]       clz_a;
   logic [5:0]       n_load;
   logic [WIDTH+1:0] r_wide;
   logic [WIDTH+1:0] trial;

   // Operand magnitudes; negation only applies to signed negative operands.
   always_comb begin
      abs_a = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
      abs_b = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
   end

   CLZ u_clz (
      .datain  (abs_a),
      .dataout (clz_a)
   );

   assign n_load = 6'd32 - clz_a;

   // One restoring step: shift {r,q} left, then try subtracting |b|.
   // The extra top bit of r_wide/trial is the borrow (negative) indicator.
   always_comb begin
      r_wide = {r_q, q_sr_q[WIDTH-1]};
      trial  = r_wide - {2'b00, abs_b};
   end

   // Next-state and datapath updates; every register holds by default.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      q_sr_d  = q_sr_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = dividend;
               b_d     = divisor;
               sgn_d   = is_signed;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            q_sr_d = abs_a << clz_a;
            r_d    = '0;
            cnt_d  = n_load;
            qneg_d = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            rneg_d = sgn_q & a_q[WIDTH-1];
            dbz_d  = 1'b0;
            if (b_q == '0) begin
               quot_d  = DIV0_QUOTIENT;
               rem_d   = a_q;
               dbz_d   = 1'b1;
               state_d = S_DONE;
            end else if (n_load == 6'd0) begin
               state_d = S_FIX;
            end else begin
               state_d = S_ITER;
            end
         end
         S_ITER: begin
            q_sr_d = {q_sr_q[WIDTH-2:0], ~trial[WIDTH+1]};
            r_d    = trial[WIDTH+1] ? r_wide[WIDTH:0] : trial[WIDTH:0];
            cnt_d  = cnt_q - 6'd1;
            if (cnt_q == 6'd1) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            quot_d  = qneg_q ? -q_sr_q : q_sr_q;
            rem_d   = rneg_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         q_sr_q  <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         q_sr_q  <= q_sr_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_div.sv
// Scoreboard bench for mdu_div: the driver pushes the expected result of
// every accepted operation, a monitor pops and checks it on each done.
module tb_mdu_div;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        is_signed;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] quotient;
   logic [31:0] remainder;
   logic        div_by_zero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          lat;
      int          start_cyc;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   logic prev_done = 1'b0;

   mdu_div #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int sig_bits(logic [31:0] m);
      int k = 0;
      for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
      return k;
   endfunction

   // Reference: plain 64-bit arithmetic with truncating division semantics.
   function automatic exp_t model(logic sgn, logic [31:0] a, logic [31:0] b);
      exp_t        e;
      longint      da;
      longint      dv;
      logic [31:0] mag;
      e.sgn = sgn;
      e.a   = a;
      e.b   = b;
      e.start_cyc = 0;
      if (b == 32'd0) begin
         e.q   = 32'hFFFF_FFFF;
         e.r   = a;
         e.dbz = 1'b1;
         e.lat = 2;
      end else begin
         if (sgn) begin
            da = longint'($signed(a));
            dv = longint'($signed(b));
         end else begin
            da = longint'({32'd0, a});
            dv = longint'({32'd0, b});
         end
         e.q   = 32'(da / dv);
         e.r   = 32'(da % dv);
         e.dbz = 1'b0;
         mag   = (sgn && a[31]) ? -a : a;
         e.lat = sig_bits(mag) + 3;
      end
      return e;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         check("done_single_cycle", 32'(prev_done), 32'd0);
         if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done: got done with no outstanding op at cycle %0d", cyc);
         end else begin
            e = sb_q.pop_front();
            $display("[TB] %s 0x%08h / 0x%08h -> q=0x%08h r=0x%08h dbz=%0b lat=%0d",
                     e.sgn ? "DIV " : "DIVU", e.a, e.b, quotient, remainder,
                     div_by_zero, cyc - e.start_cyc);
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            check("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
         end
      end
      prev_done = (done === 1'b1);
   end

   task automatic wait_idle();
      int n = 0;
      while (sb_q.size() != 0 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (sb_q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: got %0d outstanding ops, required 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Issue one request at a negedge; optionally record it and wait for done.
   task automatic issue(logic sgn, logic [31:0] a, logic [31:0] b,
                        bit expect_result, bit wait_done);
      exp_t e;
      @(negedge clk);
      check("busy_idle", 32'(busy), 32'd0);
      is_signed = sgn;
      dividend  = a;
      divisor   = b;
      start     = 1'b1;
      if (expect_result) begin
         e = model(sgn, a, b);
         e.start_cyc = cyc;
         sb_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_load", 32'(busy), 32'd1);
      if (wait_done) wait_idle();
   endtask

   initial begin
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      rst_n     = 1'b0;
      start     = 1'b0;
      is_signed = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_quotient", quotient, 32'd0);
      check("reset_remainder", remainder, 32'd0);
      check("reset_dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;

      // Directed cases, including back-to-back starts.
      issue(1'b0, 32'd100, 32'd7, 1'b1, 1'b1);
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
      issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1);
      issue(1'b0, 32'd5, 32'd0, 1'b1, 1'b1);
      issue(1'b0, 32'd0, 32'd3, 1'b1, 1'b1);
      issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b1);
      issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1);

      // A start pulse during ITER must be ignored.
      issue(1'b0, 32'hFFFF_FFFF, 32'd3, 1'b1, 1'b0);
      repeat (3) @(negedge clk);
      is_signed = 1'b1;
      dividend  = 32'd1234;
      divisor   = 32'd0;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      // Reset during ITER clears outputs at once and produces no done.
      issue(1'b0, 32'hFFFF_0000, 32'd9, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_quotient", quotient, 32'd0);
      check("abort_remainder", remainder, 32'd0);
      check("abort_dbz", 32'(div_by_zero), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (45) @(negedge clk);
      issue(1'b1, 32'hFFFF_FF00, 32'd10, 1'b1, 1'b1);

      // Randomized operations over varied magnitudes.
      for (int i = 0; i < 40; i++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) a = -a;
         case ($urandom_range(0, 9))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            default: b = $urandom >> $urandom_range(0, 31);
         endcase
         if ($urandom_range(0, 3) == 0) b = -b;
         issue(sgn, a, b, 1'b1, 1'b1);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global guard so the run always terminates.
   initial begin
      #1000000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "timeout");
   end

endmodule
